alu_op_sequencer: RTL and testbench

- Parametrised next-generation ALU control for the RV32 core.
- Decodes opcode/funct3/funct7 into a widened ALU_OP_W-bit operation code and registers it as the ID->EX boundary, using a valid/ready handshake.
- Sequences multi-cycle operations (M-extension MUL*/DIV*/REM*) with an internal latency counter, a busy indication and a done pulse.
- Sits between the instruction decoder and the ALU/multiplier-divider datapath; the hazard unit uses it as the stall source.

---
 rtl/alu_op_pkg.sv | 74 +++++++
 rtl/alu_op_decode.sv | 80 ++++++++
 rtl/alu_op_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_pkg.sv
// -----------------------------------------------------------------------------
// alu_op_pkg
// Shared definitions for the ALU control path of the RV32 core: base alu_op
// encodings (5-bit, widened by the decoder), RV32 opcode constants, the
// M-extension funct7 value, the sequencer state type and the helper that maps
// funct3 to the integer ALU operation.
// Used by alu_op_decode and alu_op_sequencer. No ports.
// -----------------------------------------------------------------------------
package alu_op_pkg;

  // Width of the base encoding. The MSB marks an M-extension op; the decoder
  // moves it to bit ALU_OP_W-1 and zero-fills the bits in between.
  localparam int OP_CODE_W = 5;

  localparam logic [OP_CODE_W-1:0] ALU_ADD    = 5'b00000;
  localparam logic [OP_CODE_W-1:0] ALU_SUB    = 5'b00001;
  localparam logic [OP_CODE_W-1:0] ALU_AND    = 5'b00010;
  localparam logic [OP_CODE_W-1:0] ALU_OR     = 5'b00011;
  localparam logic [OP_CODE_W-1:0] ALU_XOR    = 5'b00100;
  localparam logic [OP_CODE_W-1:0] ALU_SLT    = 5'b00101;
  localparam logic [OP_CODE_W-1:0] ALU_SLTU   = 5'b00110;
  localparam logic [OP_CODE_W-1:0] ALU_SLL    = 5'b00111;
  localparam logic [OP_CODE_W-1:0] ALU_SRL    = 5'b01000;
  localparam logic [OP_CODE_W-1:0] ALU_SRA    = 5'b01001;
  localparam logic [OP_CODE_W-1:0] ALU_CLR    = 5'b01010;
  localparam logic [OP_CODE_W-1:0] ALU_PASS_B = 5'b01111;
  localparam logic [OP_CODE_W-1:0] ALU_MUL    = 5'b10000;
  localparam logic [OP_CODE_W-1:0] ALU_MULH   = 5'b10001;
  localparam logic [OP_CODE_W-1:0] ALU_MULHSU = 5'b10010;
  localparam logic [OP_CODE_W-1:0] ALU_MULHU  = 5'b10011;
  localparam logic [OP_CODE_W-1:0] ALU_DIV    = 5'b10100;
  localparam logic [OP_CODE_W-1:0] ALU_DIVU   = 5'b10101;
  localparam logic [OP_CODE_W-1:0] ALU_REM    = 5'b10110;
  localparam logic [OP_CODE_W-1:0] ALU_REMU   = 5'b10111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    MC    = 2'd2
  } seq_state_t;

  // Integer op selected by funct3. 'alt' picks SUB over ADD and SRA over SRL;
  // the caller decides whether funct7[5] is allowed to drive it.
  function automatic logic [OP_CODE_W-1:0] arith_code(input logic [2:0] f3,
                                                      input logic       alt);
    logic [OP_CODE_W-1:0] code;
    code = ALU_ADD;
    case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Pure combinational decode of {opcode, funct3, funct7} into the widened ALU
// operation code. Shared with the hazard unit.
//
// Ports:
//   opcode  [6:0]          instruction[6:0]
//   funct3  [2:0]          instruction[14:12]
//   funct7  [6:0]          instruction[31:25] (imm[11:5] for shifts)
//   alu_op  [ALU_OP_W-1:0] operation code, MSB set for M-extension ops
//   illegal                instruction not recognised (alu_op = PASS_B)
//   is_mc                  op needs the multi-cycle multiplier/divider
//   is_div                 multi-cycle op is DIV/DIVU/REM/REMU
//
// Configuration: macro ALU_OP_SEQ_RV32M_EN enables M-extension decode; when it
// is undefined, R-type with funct7 = 0000001 is illegal and is_mc/is_div are 0.
// ALU_OP_W must be at least 5.
// -----------------------------------------------------------------------------
module alu_op_decode
  import alu_op_pkg::*;
#(
  parameter int ALU_OP_W = 5
) (
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal,
  output logic                is_mc,
  output logic                is_div
);

  logic [OP_CODE_W-1:0] w_code;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    w_code  = ALU_PASS_B;
    illegal = 1'b0;
    is_mc   = 1'b0;
    is_div  = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == FUNCT7_M) begin
`ifdef ALU_OP_SEQ_RV32M_EN
          w_code = {ALU_MUL[OP_CODE_W-1:3], funct3};
          is_mc  = 1'b1;
          is_div = funct3[2];
`else
          illegal = 1'b1;
`endif
        end else begin
          w_code = arith_code(funct3, funct7[5]);
        end
      end
      // Only SRAI looks at funct7[5]; ADDI with that bit set is still ADD.
      OPC_OP_IMM: w_code = arith_code(funct3, (funct3 == 3'b101) && funct7[5]);
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_BRANCH,
      OPC_LUI, OPC_AUIPC, OPC_JAL: w_code = ALU_ADD;
      OPC_SYSTEM: begin
        // CSRRW/CSRRS/CSRRC and immediate forms share funct3[1:0].
        case (funct3[1:0])
          2'b01:   w_code = ALU_PASS_B;
          2'b10:   w_code = ALU_OR;
          2'b11:   w_code = ALU_CLR;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  // Widen: M flag to the MSB, base code in the low bits, zeros between.
  always_comb begin
    alu_op                      = '0;
    alu_op[OP_CODE_W-2:0]       = w_code[OP_CODE_W-2:0];
    alu_op[ALU_OP_W-1]          = w_code[OP_CODE_W-1];
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// ID->EX boundary register for the ALU operation code with a valid/ready
// handshake on both sides, plus sequencing of multi-cycle M-extension ops
// (latency counter, busy stall request and done pulse).
//
// Ports:
//   clk, reset        core clock; synchronous active-high reset
//   flush             drop any held or in-flight op
//   in_valid/in_ready decoder handshake
//   opcode/funct3/funct7 instruction fields to decode
//   out_valid/out_ready EX handshake
//   alu_op, illegal   registered decode result, stable while out_valid
//   mc_busy           multi-cycle unit occupied (stall source)
//   mc_done           one-cycle pulse when the multi-cycle result is ready
//
// Configuration: macro ALU_OP_SEQ_RV32M_EN enables the MC state and latency
// counter; when undefined, mc_busy and mc_done are tied 0.
// Parameters: ALU_OP_W >= 5, MUL_LAT/DIV_LAT >= 1, 2^CNT_W > max latency.
// -----------------------------------------------------------------------------
module alu_op_sequencer
  import alu_op_pkg::*;
#(
  parameter int ALU_OP_W = 5,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal,
  output logic                mc_busy,
  output logic                mc_done
);

  // Counter load values: the done cycle is the one where the counter is 0,
  // so loading LAT-1 at the handshake gives done exactly LAT cycles later.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  seq_state_t r_state;
  seq_state_t w_next_state;

  logic [ALU_OP_W-1:0] r_alu_op;
  logic                r_illegal;

  logic [ALU_OP_W-1:0] w_dec_op;
  logic                w_dec_illegal;
  logic                w_dec_is_mc;
  logic                w_dec_is_div;

  logic                w_accept;      // capture the decoded instruction
  logic                w_head_is_mc;  // op held for EX is multi-cycle

`ifdef ALU_OP_SEQ_RV32M_EN
  logic                r_is_mc;
  logic                r_is_div;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_issue_mc;    // M op handed to EX this cycle
  logic                w_cnt_zero;

  assign w_head_is_mc = r_is_mc;
  assign w_cnt_zero   = (r_cnt == '0);
`else
  logic                w_unused;

  assign w_head_is_mc = 1'b0;
  assign w_unused     = ^{w_dec_is_mc, w_dec_is_div, MUL_LOAD, DIV_LOAD};
`endif

  alu_op_decode #(
    .ALU_OP_W (ALU_OP_W)
  ) u_decode (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .alu_op  (w_dec_op),
    .illegal (w_dec_illegal),
    .is_mc   (w_dec_is_mc),
    .is_div  (w_dec_is_div)
  );

  // Next state, handshake and capture strobes.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    in_ready     = 1'b0;
`ifdef ALU_OP_SEQ_RV32M_EN
    w_issue_mc   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          if (w_head_is_mc) begin
`ifdef ALU_OP_SEQ_RV32M_EN
            w_issue_mc   = 1'b1;
            w_next_state = MC;
`endif
          end else begin
            // EX drains the held op, so a new one can be taken in the same
            // cycle without a bubble.
            in_ready = 1'b1;
            if (in_valid) begin
              w_accept = 1'b1;
            end else begin
              w_next_state = IDLE;
            end
          end
        end
      end
`ifdef ALU_OP_SEQ_RV32M_EN
      MC: begin
        if (w_cnt_zero) begin
          w_next_state = IDLE;
        end
      end
`endif
      default: w_next_state = IDLE;
    endcase

    // Flush discards whatever the decoder presents this cycle as well.
    if (flush) begin
      w_next_state = IDLE;
      w_accept     = 1'b0;
      in_ready     = 1'b0;
`ifdef ALU_OP_SEQ_RV32M_EN
      w_issue_mc   = 1'b0;
`endif
    end
    if (reset) begin
      in_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) for every flop so all registers update from the
    // same pre-edge values regardless of block ordering.
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_op  <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_alu_op  <= w_dec_op;
      r_illegal <= w_dec_illegal;
    end
  end

`ifdef ALU_OP_SEQ_RV32M_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_mc  <= 1'b0;
      r_is_div <= 1'b0;
    end else if (w_accept) begin
      r_is_mc  <= w_dec_is_mc;
      r_is_div <= w_dec_is_div;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_cnt <= '0;
    end else if (w_issue_mc) begin
      r_cnt <= r_is_div ? DIV_LOAD : MUL_LOAD;
    end else if ((r_state == MC) && !w_cnt_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign mc_busy = (r_state == MC);
  // A result dropped by flush or reset is never reported as done.
  assign mc_done = (r_state == MC) && w_cnt_zero && !flush && !reset;
`else
  assign mc_busy = 1'b0;
  assign mc_done = 1'b0;
`endif

  assign out_valid = (r_state == ISSUE);
  assign alu_op    = r_alu_op;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Self-checking bench for alu_op_sequencer: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
// Honours ALU_OP_SEQ_RV32M_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int ALU_OP_W = 5;
  localparam int MUL_LAT  = 2;
  localparam int DIV_LAT  = 32;
  localparam int CNT_W    = 6;

  localparam logic [6:0] R_OP   = 7'h33;
  localparam logic [6:0] R_IMM  = 7'h13;
  localparam logic [6:0] R_SYS  = 7'h73;

  logic                clk;
  logic                reset;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic                out_valid;
  logic                out_ready;
  logic [ALU_OP_W-1:0] alu_op;
  logic                illegal;
  logic                mc_busy;
  logic                mc_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what EX currently sees, and how many cycles the
  // multi-cycle unit still owes.
  bit         m_have;
  logic [4:0] m_op;
  bit         m_ill;
  bit         m_mc;
  int         m_lat;
  int         m_busy_left;
  bit         m_after_reset;
  int         arith_base [8];

  alu_op_sequencer #(
    .ALU_OP_W (ALU_OP_W),
    .MUL_LAT  (MUL_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .illegal   (illegal),
    .mc_busy   (mc_busy),
    .mc_done   (mc_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decode straight from the instruction tables.
  task automatic ref_decode(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                            output logic [4:0] op, output bit ill, output bit mc, output int lat);
    op  = 5'd15;
    ill = 1'b0;
    mc  = 1'b0;
    lat = 0;
    if (opc == R_OP && f7 == 7'd1) begin
`ifdef ALU_OP_SEQ_RV32M_EN
      op  = 5'(16 + int'(f3));
      mc  = 1'b1;
      lat = (f3 >= 3'd4) ? DIV_LAT : MUL_LAT;
`else
      ill = 1'b1;
`endif
    end else if (opc == R_OP) begin
      op = 5'(arith_base[f3] + (((f3 == 3'd0 || f3 == 3'd5) && f7[5]) ? 1 : 0));
    end else if (opc == R_IMM) begin
      op = 5'(arith_base[f3] + ((f3 == 3'd5 && f7[5]) ? 1 : 0));
    end else if (opc inside {7'h03, 7'h23, 7'h67, 7'h63, 7'h37, 7'h17, 7'h6F}) begin
      op = 5'd0;
    end else if (opc == R_SYS) begin
      case (f3[1:0])
        2'd0:    ill = 1'b1;
        2'd2:    op  = 5'd3;
        2'd3:    op  = 5'd10;
        default: op  = 5'd15;
      endcase
    end else begin
      ill = 1'b1;
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic tick(input bit rst, input bit fl, input bit iv, input bit ordy,
                      input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    logic [4:0] d_op;
    bit         d_ill;
    bit         d_mc;
    int         d_lat;
    bit         exp_ready;
    bit         load;
    @(negedge clk);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    opcode    = opc;
    funct3    = f3;
    funct7    = f7;
    #1;
    exp_ready = !rst && !fl && (m_busy_left == 0) && (!m_have || (ordy && !m_mc));
    check("out_valid", out_valid, m_have);
    check("in_ready", in_ready, exp_ready);
    check("mc_busy", mc_busy, m_busy_left > 0);
    check("mc_done", mc_done, (m_busy_left == 1) && !rst && !fl);
    if (m_have || m_after_reset) begin
      check("alu_op", alu_op, m_op);
      check("illegal", illegal, m_ill);
    end

    ref_decode(opc, f3, f7, d_op, d_ill, d_mc, d_lat);
    load = 1'b0;
    if (rst) begin
      m_have = 0; m_busy_left = 0; m_op = '0; m_ill = 0; m_after_reset = 1;
    end else if (fl) begin
      m_have = 0; m_busy_left = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (m_have && ordy) begin
      if (m_mc) begin
        m_have = 0;
        m_busy_left = m_lat;
      end else if (iv) begin
        load = 1'b1;
      end else begin
        m_have = 0;
      end
    end else if (!m_have && iv) begin
      load = 1'b1;
    end
    if (load) begin
      m_have = 1; m_op = d_op; m_ill = d_ill; m_mc = d_mc; m_lat = d_lat;
      m_after_reset = 0;
    end
  endtask

  task automatic idle_ticks(input int n, input bit ordy);
    for (int i = 0; i < n; i++) tick(0, 0, 0, ordy, 7'h00, 3'd0, 7'h00);
  endtask

  task automatic rand_instr(output logic [6:0] opc, output logic [2:0] f3, output logic [6:0] f7);
    case ($urandom_range(0, 11))
      0, 1, 2: opc = R_OP;
      3, 4:    opc = R_IMM;
      5:       opc = R_SYS;
      6:       opc = 7'h03;
      7:       opc = 7'h23;
      8:       opc = 7'h63;
      9:       opc = 7'h6F;
      10:      opc = 7'h37;
      default: opc = 7'($urandom);
    endcase
    f3 = 3'($urandom);
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
  endtask

  int         done_at;
  int         busy_cnt;
  logic [6:0] r_opc;
  logic [2:0] r_f3;
  logic [6:0] r_f7;

  initial begin
    arith_base = '{0, 7, 5, 6, 4, 8, 3, 2};
    clk = 0; reset = 1; flush = 0; in_valid = 0; out_ready = 0;
    opcode = '0; funct3 = '0; funct7 = '0;
    m_have = 0; m_op = '0; m_ill = 0; m_mc = 0; m_lat = 0; m_busy_left = 0;
    m_after_reset = 1;
    repeat (3) @(posedge clk);

    // Reset values.
    @(negedge clk);
    reset = 0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_illegal", illegal, 0);
    check("rst_mc_busy", mc_busy, 0);
    check("rst_mc_done", mc_done, 0);

    // SUB then ADDI with funct7[5] set.
    tick(0, 0, 1, 1, R_OP, 3'd0, 7'h20);
    tick(0, 0, 1, 1, R_IMM, 3'd0, 7'h20);
    check("tp_sub", alu_op, 5'b00001);
    tick(0, 0, 0, 1, 7'h00, 3'd0, 7'h00);
    check("tp_addi", alu_op, 5'b00000);

    // XOR then SRAI back-to-back.
    tick(0, 0, 1, 1, R_OP, 3'd4, 7'h00);
    tick(0, 0, 1, 1, R_IMM, 3'd5, 7'h20);
    check("tp_xor", alu_op, 5'b00100);
    tick(0, 0, 0, 1, 7'h00, 3'd0, 7'h00);
    check("tp_srai", alu_op, 5'b01001);
    check("tp_srai_valid", out_valid, 1);

    // Backpressure on OR.
    tick(0, 0, 1, 1, R_OP, 3'd6, 7'h00);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0, R_OP, 3'd7, 7'h00);
      check("tp_bp_op", alu_op, 5'b00011);
      check("tp_bp_ready", in_ready, 0);
    end
    idle_ticks(2, 1);

    // DIV with full latency.
    tick(0, 0, 1, 1, R_OP, 3'd4, 7'h01);
    tick(0, 0, 0, 1, 7'h00, 3'd0, 7'h00);
`ifdef ALU_OP_SEQ_RV32M_EN
    check("tp_div_op", alu_op, 5'b10100);
    check("tp_div_ill", illegal, 0);
`else
    check("tp_div_op", alu_op, 5'b01111);
    check("tp_div_ill", illegal, 1);
`endif
    done_at = 0;
    busy_cnt = 0;
    for (int i = 1; i <= DIV_LAT + 4; i++) begin
      tick(0, 0, 0, 1, 7'h00, 3'd0, 7'h00);
      if (mc_busy === 1'b1) busy_cnt++;
      if (mc_done === 1'b1 && done_at == 0) done_at = i;
    end
`ifdef ALU_OP_SEQ_RV32M_EN
    check("tp_div_done_lat", done_at, DIV_LAT);
    check("tp_div_busy_cycles", busy_cnt, DIV_LAT);
`else
    check("tp_div_done_lat", done_at, 0);
    check("tp_div_busy_cycles", busy_cnt, 0);
`endif

    // MUL latency through the model.
    tick(0, 0, 1, 1, R_OP, 3'd1, 7'h01);
    tick(0, 0, 0, 1, 7'h00, 3'd0, 7'h00);
    idle_ticks(MUL_LAT + 2, 1);

    // Flush on cycle 10 of a DIV, then reset on cycle 10 of another.
    for (int k = 0; k < 2; k++) begin
      tick(0, 0, 1, 1, R_OP, 3'd6, 7'h01);
      tick(0, 0, 0, 1, 7'h00, 3'd0, 7'h00);
      idle_ticks(9, 1);
      tick(k == 1, k == 0, 1, 1, R_OP, 3'd0, 7'h00);
      tick(0, 0, 0, 1, 7'h00, 3'd0, 7'h00);
      check("tp_abort_busy", mc_busy, 0);
      check("tp_abort_ready", in_ready, 1);
      idle_ticks(DIV_LAT, 1);
    end

    // Illegal opcode and CSR funct3 100.
    tick(0, 0, 1, 1, 7'h7F, 3'd0, 7'h00);
    tick(0, 0, 1, 1, R_SYS, 3'd4, 7'h00);
    check("tp_ill_opc_op", alu_op, 5'b01111);
    check("tp_ill_opc_flag", illegal, 1);
    tick(0, 0, 0, 1, 7'h00, 3'd0, 7'h00);
    check("tp_ill_csr_op", alu_op, 5'b01111);
    check("tp_ill_csr_flag", illegal, 1);
    idle_ticks(1, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_instr(r_opc, r_f3, r_f7);
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, r_opc, r_f3, r_f7);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
